// File: rtl/queue_dispatcher.sv
// Ticket queue with two-teller dispatcher, call handshake and per-teller busy timeout.
// Latency: arrivals, acks and frees take effect on the next clk edge; a call is raised one cycle after the queue and a teller are ready.
// Backpressure: call_valid/call_teller/call_ticket hold until call_ack; an arrival into a full queue is dropped and flagged on reject.
//
// Ports:
//   clk, reset        single clock, asynchronous active-high reset
//   sec_clk           slow square wave; each rising edge is one second
//   arrive            one-cycle pulse, customer takes a ticket
//   teller_done[1:0]  one-cycle pulse per teller, service finished
//   call_ack          announcer accepted the pending call
//   call_valid, call_teller, call_ticket   pending call to a teller
//   next_ticket       ticket number for the next accepted arrival
//   waiting, full, empty, reject           queue occupancy and drop indication
//   teller_busy[1:0], timeout_flag[1:0]    teller state and auto-free pulses
module queue_dispatcher #(
    parameter int QMAX        = 7,
    parameter int TICKET_W    = 4,
    parameter int TIMEOUT_SEC = 30
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sec_clk,
    input  logic                arrive,
    input  logic [1:0]          teller_done,
    input  logic                call_ack,
    output logic                call_valid,
    output logic                call_teller,
    output logic [TICKET_W-1:0] call_ticket,
    output logic [TICKET_W-1:0] next_ticket,
    output logic [3:0]          waiting,
    output logic                full,
    output logic                empty,
    output logic                reject,
    output logic [1:0]          teller_busy,
    output logic [1:0]          timeout_flag
);

    typedef enum logic {
        IDLE = 1'b0,
        CALL = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                start_call;
    logic                sel_teller;
    logic                rr;
    logic                sec_q;
    logic                sec_tick;
    logic                call_acc;
    logic                arr_acc;
    logic [TICKET_W-1:0] head_ticket;
    logic [7:0]          timer [2];

    // One register on sec_clk; the tick is the cycle where it is high but was low last edge.
    assign sec_tick = sec_clk & ~sec_q;

    assign full       = (waiting == 4'(QMAX));
    assign empty      = (waiting == 4'd0);
    assign call_valid = (state == CALL);
    assign call_acc   = (state == CALL) && call_ack;
    // Uses the pre-edge count, so a same-cycle accepted call never makes room for this arrival.
    assign arr_acc    = arrive && !full;

    // Both free: round-robin pointer. One free: busy[0] set means teller 1 is the free one.
    always_comb begin
        sel_teller = teller_busy[0];
        if (teller_busy == 2'b00) begin
            sel_teller = rr;
        end
    end

    always_comb begin
        state_nxt  = state;
        start_call = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && (teller_busy != 2'b11)) begin
                    state_nxt  = CALL;
                    start_call = 1'b1;
                end
            end
            CALL: begin
                if (call_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            call_teller <= 1'b0;
            call_ticket <= '0;
            rr          <= 1'b0;
            sec_q       <= 1'b0;
        end else begin
            state <= state_nxt;
            sec_q <= sec_clk;
            if (start_call) begin
                call_teller <= sel_teller;
                call_ticket <= head_ticket;
            end
            if (call_acc) begin
                rr <= ~call_teller;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waiting     <= 4'd0;
            next_ticket <= '0;
            head_ticket <= '0;
            reject      <= 1'b0;
        end else begin
            reject <= arrive && full;
            if (arr_acc) begin
                next_ticket <= next_ticket + 1'b1;
            end
            if (call_acc) begin
                head_ticket <= head_ticket + 1'b1;
            end
            case ({arr_acc, call_acc})
                2'b10:   waiting <= waiting + 4'd1;
                2'b01:   waiting <= waiting - 4'd1;
                default: waiting <= waiting;
            endcase
        end
    end

    // Per-teller busy/timer. A teller being called is never busy, so the ack load
    // cannot collide with done or expiry; done wins over expiry and suppresses the flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            teller_busy  <= 2'b00;
            timeout_flag <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                timer[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                timeout_flag[i] <= 1'b0;
                if (call_acc && (call_teller == 1'(i))) begin
                    teller_busy[i] <= 1'b1;
                    timer[i]       <= 8'(TIMEOUT_SEC);
                end else if (teller_busy[i]) begin
                    if (teller_done[i]) begin
                        teller_busy[i] <= 1'b0;
                        timer[i]       <= 8'd0;
                    end else if (sec_tick) begin
                        if (timer[i] <= 8'd1) begin
                            teller_busy[i]  <= 1'b0;
                            timer[i]        <= 8'd0;
                            timeout_flag[i] <= 1'b1;
                        end else begin
                            timer[i] <= timer[i] - 8'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_queue_dispatcher.sv
module tb_queue_dispatcher;

    localparam int QMAX = 7;
    localparam int TW   = 4;
    localparam int TO   = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          sec_clk;
    logic          arrive;
    logic [1:0]    teller_done;
    logic          call_ack;
    logic          call_valid;
    logic          call_teller;
    logic [TW-1:0] call_ticket;
    logic [TW-1:0] next_ticket;
    logic [3:0]    waiting;
    logic          full;
    logic          empty;
    logic          reject;
    logic [1:0]    teller_busy;
    logic [1:0]    timeout_flag;

    queue_dispatcher #(.QMAX(QMAX), .TICKET_W(TW), .TIMEOUT_SEC(TO)) dut (
        .clk(clk), .reset(reset), .sec_clk(sec_clk), .arrive(arrive),
        .teller_done(teller_done), .call_ack(call_ack), .call_valid(call_valid),
        .call_teller(call_teller), .call_ticket(call_ticket), .next_ticket(next_ticket),
        .waiting(waiting), .full(full), .empty(empty), .reject(reject),
        .teller_busy(teller_busy), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the queue is a list of ticket numbers, tellers are busy flags
    // with seconds remaining, the pending call is a (teller, ticket) record.
    int     m_q[$];
    int     m_nt;
    bit [1:0] m_busy;
    bit [1:0] m_tflag;
    int     m_tmr[2];
    bit     m_rr;
    bit     m_calling;
    bit     m_ct;
    int     m_ctk;
    bit     m_reject;
    bit     m_sec;

    task automatic model_reset();
        m_q.delete();
        m_nt = 0; m_busy = 0; m_tflag = 0; m_tmr[0] = 0; m_tmr[1] = 0;
        m_rr = 0; m_calling = 0; m_ct = 0; m_ctk = 0; m_reject = 0; m_sec = 0;
    endtask

    task automatic model_step(input bit a, input bit [1:0] d, input bit k, input bit s);
        bit tick;
        bit was_full;
        int n_pre;
        int head_pre;
        bit [1:0] busy_pre;
        bit accepted;
        tick     = s && !m_sec;
        n_pre    = m_q.size();
        was_full = (n_pre == QMAX);
        head_pre = (n_pre > 0) ? m_q[0] : 0;
        busy_pre = m_busy;
        accepted = m_calling && k;

        m_reject = a && was_full;
        m_tflag  = 0;
        for (int i = 0; i < 2; i++) begin
            if (accepted && (int'(m_ct) == i)) begin
                m_busy[i] = 1; m_tmr[i] = TO;
            end else if (m_busy[i]) begin
                if (d[i]) m_busy[i] = 0;
                else if (tick) begin
                    m_tmr[i] = m_tmr[i] - 1;
                    if (m_tmr[i] <= 0) begin
                        m_busy[i] = 0; m_tflag[i] = 1;
                    end
                end
            end
        end

        if (accepted) void'(m_q.pop_front());
        if (a && !was_full) begin
            m_q.push_back(m_nt);
            m_nt = (m_nt + 1) % (1 << TW);
        end

        if (m_calling) begin
            if (k) begin
                m_calling = 0;
                m_rr = !m_ct;
            end
        end else if (n_pre > 0 && busy_pre != 2'b11) begin
            m_calling = 1;
            if (busy_pre == 2'b00) m_ct = m_rr;
            else m_ct = (busy_pre == 2'b01);
            m_ctk = head_pre;
        end
        m_sec = s;
    endtask

    task automatic compare_all();
        check("waiting", waiting, m_q.size());
        check("next_ticket", next_ticket, m_nt);
        check("full", full, m_q.size() == QMAX);
        check("empty", empty, m_q.size() == 0);
        check("reject", reject, m_reject);
        check("teller_busy", teller_busy, m_busy);
        check("timeout_flag", timeout_flag, m_tflag);
        check("call_valid", call_valid, m_calling);
        if (m_calling) begin
            check("call_teller", call_teller, m_ct);
            check("call_ticket", call_ticket, m_ctk);
        end
    endtask

    task automatic cycle(input bit a, input bit [1:0] d, input bit k, input bit s);
        arrive = a; teller_done = d; call_ack = k; sec_clk = s;
        @(posedge clk);
        #1;
        model_step(a, d, k, s);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 2'b00, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1; arrive = 0; teller_done = 0; call_ack = 0; sec_clk = 0;
        @(posedge clk);
        #1;
        model_reset();
        compare_all();
        reset = 0;
    endtask

    initial begin
        int  w;
        bit  tl;
        bit  lvl;
        int  cnt;
        do_reset();
        check("rst_empty", empty, 1);
        check("rst_valid", call_valid, 0);

        // Three arrivals, first call to teller 0 with ticket 0.
        cycle(1, 0, 0, 0); cycle(1, 0, 0, 0); cycle(1, 0, 0, 0); idle(1);
        check("arr3_waiting", waiting, 3);
        check("arr3_next", next_ticket, 3);
        check("call0_valid", call_valid, 1);
        check("call0_teller", call_teller, 0);
        check("call0_ticket", call_ticket, 0);
        cycle(0, 0, 1, 0);
        check("ack0_busy", teller_busy, 2'b01);
        check("ack0_waiting", waiting, 2);
        check("ack0_gap", call_valid, 0);

        // Second call goes to teller 1 and holds while unacknowledged.
        idle(1);
        check("call1_teller", call_teller, 1);
        check("call1_ticket", call_ticket, 1);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            check("hold_teller", call_teller, 1);
            check("hold_ticket", call_ticket, 1);
        end
        cycle(0, 0, 1, 0);
        check("ack1_busy", teller_busy, 2'b11);
        check("ack1_waiting", waiting, 1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("nofree_valid", call_valid, 0);
        end

        // Fill the queue, then two rejected arrivals.
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0);
        check("fill_full", full, 1);
        check("fill_waiting", waiting, 7);
        cycle(1, 0, 0, 0);
        check("rej_pulse", reject, 1);
        cycle(1, 0, 0, 0);
        idle(1);
        check("rej_clear", reject, 0);
        check("rej_next", next_ticket, 9);
        check("rej_waiting", waiting, 7);

        // Two seconds: both tellers time out on the same edge.
        cycle(0, 0, 0, 1); cycle(0, 0, 0, 0); cycle(0, 0, 0, 1);
        check("to_busy", teller_busy, 2'b00);
        check("to_flag", timeout_flag, 2'b11);
        cycle(0, 0, 0, 1);
        check("to_flag_once", timeout_flag, 2'b00);
        check("to_call_teller", call_teller, 0);
        check("to_call_ticket", call_ticket, 2);
        cycle(0, 0, 1, 0);
        idle(1);
        check("call3_teller", call_teller, 1);

        // Done coinciding with the expiring second: free, no timeout pulse.
        cycle(0, 0, 0, 1); cycle(0, 0, 0, 0); cycle(0, 2'b01, 0, 1);
        check("done_busy", teller_busy[0], 0);
        check("done_noflag", timeout_flag, 2'b00);

        // Reset while a call is pending drops it immediately.
        check("pre_rst_valid", call_valid, 1);
        reset = 1;
        #1;
        check("async_valid", call_valid, 0);
        check("async_waiting", waiting, 0);
        check("async_busy", teller_busy, 0);
        check("async_next", next_ticket, 0);
        @(posedge clk);
        #1;
        model_reset();
        compare_all();
        reset = 0;

        // Ticket wrap across 17 served customers.
        for (int i = 0; i < 17; i++) begin
            cycle(1, 0, 0, 0);
            w = 0;
            while (!call_valid && w < 8) begin
                idle(1);
                w++;
            end
            check("wrap_valid", call_valid, 1);
            check("wrap_ticket", call_ticket, i % 16);
            tl = call_teller;
            cycle(0, 0, 1, 0);
            cycle(0, tl ? 2'b10 : 2'b01, 0, 0);
        end

        // Randomized traffic against the model.
        lvl = 0;
        cnt = 3;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            cnt--;
            if (cnt <= 0) begin
                lvl = !lvl;
                cnt = $urandom_range(1, 6);
            end
            cycle($urandom_range(0, 2) == 0,
                  {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)},
                  $urandom_range(0, 1) == 1, lvl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/queue_dispatcher.md
QUEUE_DISPATCHER -- requirements
Module: queue_dispatcher

Interface
REQ-001 SHALL have parameter QMAX, default 7, meaning waiting-queue capacity in customers (1..15).
REQ-002 SHALL have parameter TICKET_W, default 4, meaning ticket-number width; tickets wrap modulo 2^TICKET_W.
REQ-003 SHALL have parameter TIMEOUT_SEC, default 30, meaning seconds a teller may stay busy before it is auto-freed (1..255).
REQ-004 SHALL have ports: clk  input  1  system clock, single clock domain.
REQ-005 SHALL have ports: reset  input  1  asynchronous, active-high reset.
REQ-006 sec_clk  input  1  slow square wave from the clock divider, generated from clk; one rising edge marks one second.
REQ-007 arrive  input  1  one-cycle pulse, customer takes a ticket.
REQ-008 teller_done  input  2  one-cycle pulse per teller, service finished.
REQ-009 call_ack  input  1  display/announcer accepted the current call.
REQ-010 call_valid  output  1  call pending; call_teller  output  1  teller index; call_ticket  output  TICKET_W  ticket called.
REQ-011 next_ticket  output  TICKET_W  number issued to the next accepted arrival; waiting  output  4  queued customers.
REQ-012 full, empty, reject  output  1 each; teller_busy  output  2; timeout_flag  output  2.

Function
REQ-013 SHALL detect sec_clk rising edges with one clk-domain register; sec_tick is high for exactly one clk cycle per edge.
REQ-014 arrive with waiting < QMAX SHALL increment waiting and next_ticket (mod 2^TICKET_W) on the next clk edge.
REQ-015 arrive with waiting == QMAX SHALL leave state unchanged and pulse reject for one cycle.
REQ-016 full = (waiting == QMAX), empty = (waiting == 0), both combinational from waiting.
REQ-017 head_ticket register SHALL hold the oldest waiting ticket; it increments mod 2^TICKET_W on each accepted call.
REQ-018 Dispatch FSM SHALL have states IDLE and CALL.
REQ-019 IDLE -> CALL when waiting > 0 and at least one teller_busy bit is 0; call_teller and call_ticket (= head_ticket) are latched on that transition.
REQ-020 Teller selection: if both are free, pick the round-robin pointer rr; otherwise pick the free teller. After each accepted call, rr = ~call_teller.
REQ-021 call_valid = 1 exactly in CALL; call_teller and call_ticket SHALL stay stable while call_valid = 1 and call_ack = 0.
REQ-022 CALL with call_ack = 1 SHALL, on that edge, set teller_busy[call_teller], load that teller's timer to TIMEOUT_SEC, decrement waiting, advance head_ticket, and go to IDLE.
REQ-023 call_valid SHALL be low for at least one cycle between consecutive calls; call_ack outside CALL is ignored.
REQ-024 Arrive and an accepted call in the same cycle SHALL leave waiting unchanged; full is evaluated on the pre-edge count, so an arrival when full is rejected even if a call is accepted in that cycle.
REQ-025 Per teller, 8-bit timer SHALL decrement on sec_tick while busy; when it reaches 0, the busy bit clears and timeout_flag[i] pulses for one cycle.
REQ-026 teller_done[i] while busy SHALL clear busy on the next edge without a timeout pulse, including when it coincides with timer expiry. teller_done[i] while idle is ignored.
REQ-027 Both tellers SHALL be able to free in the same cycle; teller_busy updates are independent per teller.

Reset
REQ-028 reset SHALL asynchronously force: FSM IDLE, call_valid 0, call_teller 0, call_ticket 0, next_ticket 0, head_ticket 0, waiting 0 (empty 1, full 0), reject 0, teller_busy 00, timers 0, timeout_flag 00, rr 0, sec_clk edge register 0.
REQ-029 reset asserted during CALL SHALL drop call_valid immediately; the pending call is discarded.

Verification
REQ-030 3 arrive pulses after reset -> waiting 3, next_ticket 3; call_valid rises with call_teller 0, call_ticket 0. Ack -> teller_busy 01, waiting 2.
REQ-031 Continue without further done -> second call to teller 1, ticket 1. Ack -> teller_busy 11, waiting 1, no call_valid until a teller frees.
REQ-032 8 arrives with QMAX = 7 and no tellers free -> waiting 7, full 1, eighth arrive gives reject pulse and next_ticket 7.
REQ-033 TIMEOUT_SEC = 2, teller 0 busy, two sec_clk rising edges -> teller_busy[0] clears, timeout_flag[0] pulses once; teller_done[0] coinciding with the second edge -> no pulse.
REQ-034 Hold call_ack low 10 cycles in CALL -> call_teller and call_ticket stable. Assert reset mid-CALL -> call_valid 0 in the same cycle, all outputs at reset values.
REQ-035 Ticket wrap: 17 accepted arrivals and calls with TICKET_W = 4 -> call_ticket sequence 0..15, then 0.
